// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// hazard_pkg : shared encodings and helpers for the pipeline hazard sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_IWAIT = 2'd1;
  localparam logic [1:0] ST_IDROP = 2'd2;
  localparam logic [1:0] ST_DWAIT = 2'd3;

  localparam int REG_W = 5;
  localparam int TMO_W = 8;

  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_stall;
    logic exmem_stall;
    logic memwb_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, idex_stall: 1'b0, exmem_stall: 1'b0,
                                      memwb_bubble: 1'b0};

  // x0 is hard-wired, so a load targeting it never creates a dependency
  function automatic logic load_use(input logic             memread,
                                    input logic [REG_W-1:0] ex_rd,
                                    input logic [REG_W-1:0] rs1,
                                    input logic [REG_W-1:0] rs2,
                                    input logic             uses_rs2);
    return memread && (ex_rd != '0) && ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sat_counter.sv
//------------------------------------------------------------------------------
// hazard_sat_counter : saturating up-counter with async active-low clear
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             idex_stall_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(DMEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  logic             dwait;
  logic             lu;
  logic [1:0]       eff_state;
  logic             flush_evt;
  hz_ctrl_t         ctrl;

  assign dwait = dmem_req_i && !dmem_ready_i;
  assign lu    = load_use(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs2_i);

  // While frozen, the I-side sequencing resumes from the state saved on entry
  assign eff_state = (state_q == ST_DWAIT) ? saved_q : state_q;

  always_comb begin
    ctrl      = '0;
    state_d   = eff_state;
    saved_d   = saved_q;
    flush_evt = 1'b0;
    if (!rst_i) begin
      ctrl = CTRL_RESET;
    end else if (dwait) begin
      ctrl.ifid_stall   = 1'b1;
      ctrl.idex_stall   = 1'b1;
      ctrl.exmem_stall  = 1'b1;
      ctrl.memwb_bubble = 1'b1;
      state_d           = ST_DWAIT;
      saved_d           = eff_state;
    end else if (lu) begin
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_bubble = 1'b1;
    end else begin
      case (eff_state)
        ST_IDROP: begin
          ctrl.ifid_flush = 1'b1;
          state_d         = imem_ready_i ? ST_RUN : ST_IDROP;
        end
        ST_IWAIT: begin
          if (branch_taken_i) begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_flush = 1'b1;
            flush_evt       = 1'b1;
            state_d         = ST_IDROP;
          end else if (!imem_ready_i) begin
            ctrl.ifid_flush = 1'b1;
            state_d         = ST_IWAIT;
          end else begin
            ctrl.pc_write = 1'b1;
            state_d       = ST_RUN;
          end
        end
        default: begin
          if (branch_taken_i) begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_flush = 1'b1;
            flush_evt       = 1'b1;
            state_d         = ST_RUN;
          end else if (!imem_ready_i) begin
            ctrl.ifid_flush = 1'b1;
            state_d         = ST_IWAIT;
          end else begin
            ctrl.pc_write = 1'b1;
            state_d       = ST_RUN;
          end
        end
      endcase
    end
    ctrl.ifid_flush = ctrl.ifid_flush && !ctrl.ifid_stall;
  end

  // Timeout counter only runs while frozen; err is sticky until reset
  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (rst_i && dwait) begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_ONE;
      if ((tmo_q + TMO_ONE) == TMO_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!ctrl.pc_write),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_evt),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o     = ctrl.pc_write;
  assign ifid_stall_o   = ctrl.ifid_stall;
  assign ifid_flush_o   = ctrl.ifid_flush;
  assign idex_bubble_o  = ctrl.idex_bubble;
  assign idex_stall_o   = ctrl.idex_stall;
  assign exmem_stall_o  = ctrl.exmem_stall;
  assign memwb_bubble_o = ctrl.memwb_bubble;
  assign err_o          = err_q;
  assign state_o        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : directed self-checking bench for pipeline_hazard_ctrl
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // {pc_write, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, memwb_bubble}
  localparam logic [6:0] C_RUN    = 7'b1000000;
  localparam logic [6:0] C_LU     = 7'b0101000;
  localparam logic [6:0] C_FREEZE = 7'b0100111;
  localparam logic [6:0] C_BRANCH = 7'b1010000;
  localparam logic [6:0] C_FWAIT  = 7'b0010000;
  localparam logic [6:0] C_RESET  = 7'b0011000;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
  logic             id_uses_rs2_i, ex_memread_i, branch_taken_i;
  logic             imem_ready_i, dmem_req_i, dmem_ready_i;
  logic             pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o;
  logic             idex_stall_o, exmem_stall_o, memwb_bubble_o, err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]       state_o;
  logic [6:0]       ctl;

  int n_pass = 0;
  int n_tot  = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(255)) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .id_rs1_i (id_rs1_i), .id_rs2_i (id_rs2_i), .id_uses_rs2_i (id_uses_rs2_i),
    .ex_memread_i (ex_memread_i), .ex_rd_i (ex_rd_i), .branch_taken_i (branch_taken_i),
    .imem_ready_i (imem_ready_i), .dmem_req_i (dmem_req_i), .dmem_ready_i (dmem_ready_i),
    .pc_write_o (pc_write_o), .ifid_stall_o (ifid_stall_o), .ifid_flush_o (ifid_flush_o),
    .idex_bubble_o (idex_bubble_o), .idex_stall_o (idex_stall_o),
    .exmem_stall_o (exmem_stall_o), .memwb_bubble_o (memwb_bubble_o), .err_o (err_o),
    .stall_cnt_o (stall_cnt_o), .flush_cnt_o (flush_cnt_o), .state_o (state_o)
  );

  assign ctl = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
                idex_stall_o, exmem_stall_o, memwb_bubble_o};

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after a rising edge; outputs are sampled 1ns later
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1_i = 5'd1; id_rs2_i = 5'd2; ex_rd_i = 5'd3;
    id_uses_rs2_i = 1'b0; ex_memread_i = 1'b0; branch_taken_i = 1'b0;
    imem_ready_i = 1'b1; dmem_req_i = 1'b0; dmem_ready_i = 1'b1;
  endtask

  task automatic apply_reset();
    idle();
    rst_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b0;
    cyc(); cyc();
    #1;
    n_tot++; if (ctl !== C_RESET) $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); else n_pass++;
    n_tot++; if (state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
    n_tot++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); else n_pass++;
    n_tot++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_o); else n_pass++;
    rst_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_RUN) $display("FAIL post_reset_ctl: got %b want %b", ctl, C_RUN); else n_pass++;
    cyc();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5;
    #1;
    n_tot++; if (ctl !== C_LU) $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); else n_pass++;
    cyc();
    idle();
    #1;
    n_tot++; if (ctl !== C_RUN) $display("FAIL lu_one_cycle: got %b want %b", ctl, C_RUN); else n_pass++;
    n_tot++; if (stall_cnt_o !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); else n_pass++;
    n_tot++; if (state_o !== 2'd0) $display("FAIL lu_state: got %0d want 0", state_o); else n_pass++;
  endtask

  task automatic test_no_stall();
    apply_reset();
    ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0;
    #1;
    n_tot++; if (ctl !== C_RUN) $display("FAIL x0_no_stall: got %b want %b", ctl, C_RUN); else n_pass++;
    cyc();
    ex_rd_i = 5'd7; id_rs1_i = 5'd1; id_rs2_i = 5'd7; id_uses_rs2_i = 1'b0;
    #1;
    n_tot++; if (ctl !== C_RUN) $display("FAIL rs2_unused: got %b want %b", ctl, C_RUN); else n_pass++;
    cyc();
    id_uses_rs2_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_LU) $display("FAIL rs2_used: got %b want %b", ctl, C_LU); else n_pass++;
    cyc();
    idle();
    #1;
    n_tot++; if (stall_cnt_o !== 4'd1) $display("FAIL no_stall_cnt: got %0d want 1", stall_cnt_o); else n_pass++;
  endtask

  task automatic test_branch();
    apply_reset();
    branch_taken_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_BRANCH) $display("FAIL branch_ctl: got %b want %b", ctl, C_BRANCH); else n_pass++;
    cyc();
    idle();
    #1;
    n_tot++; if (flush_cnt_o !== 4'd1) $display("FAIL branch_cnt: got %0d want 1", flush_cnt_o); else n_pass++;
    n_tot++; if (ctl !== C_RUN || state_o !== 2'd0) $display("FAIL branch_after: got %b/%0d want %b/0", ctl, state_o, C_RUN); else n_pass++;
    branch_taken_i = 1'b1; ex_memread_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9;
    #1;
    n_tot++; if (ctl !== C_LU) $display("FAIL branch_lu_ctl: got %b want %b", ctl, C_LU); else n_pass++;
    cyc();
    idle();
    #1;
    n_tot++; if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd1) $display("FAIL branch_lu_cnt: got %0d/%0d want 1/1", flush_cnt_o, stall_cnt_o); else n_pass++;
  endtask

  task automatic test_fetch_wait();
    apply_reset();
    imem_ready_i = 1'b0;
    #1;
    n_tot++; if (ctl !== C_FWAIT || state_o !== 2'd0) $display("FAIL fw_first: got %b/%0d want %b/0", ctl, state_o, C_FWAIT); else n_pass++;
    cyc();
    n_tot++; if (ctl !== C_FWAIT || state_o !== 2'd1) $display("FAIL fw_iwait: got %b/%0d want %b/1", ctl, state_o, C_FWAIT); else n_pass++;
    cyc();
    cyc();
    imem_ready_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_RUN || state_o !== 2'd1) $display("FAIL fw_ready: got %b/%0d want %b/1", ctl, state_o, C_RUN); else n_pass++;
    cyc();
    n_tot++; if (state_o !== 2'd0 || stall_cnt_o !== 4'd3) $display("FAIL fw_back: got %0d/%0d want 0/3", state_o, stall_cnt_o); else n_pass++;
    imem_ready_i = 1'b0;
    cyc();
    branch_taken_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_BRANCH || state_o !== 2'd1) $display("FAIL iw_branch: got %b/%0d want %b/1", ctl, state_o, C_BRANCH); else n_pass++;
    cyc();
    branch_taken_i = 1'b0;
    #1;
    n_tot++; if (ctl !== C_FWAIT || state_o !== 2'd2) $display("FAIL idrop: got %b/%0d want %b/2", ctl, state_o, C_FWAIT); else n_pass++;
    cyc();
    imem_ready_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_FWAIT || state_o !== 2'd2) $display("FAIL idrop_ready: got %b/%0d want %b/2", ctl, state_o, C_FWAIT); else n_pass++;
    cyc();
    n_tot++; if (ctl !== C_RUN || state_o !== 2'd0) $display("FAIL idrop_exit: got %b/%0d want %b/0", ctl, state_o, C_RUN); else n_pass++;
    n_tot++; if (stall_cnt_o !== 4'd6 || flush_cnt_o !== 4'd1) $display("FAIL iw_cnt: got %0d/%0d want 6/1", stall_cnt_o, flush_cnt_o); else n_pass++;
  endtask

  task automatic test_dmem_timeout();
    apply_reset();
    imem_ready_i = 1'b0;
    cyc();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    #1;
    n_tot++; if (ctl !== C_FREEZE) $display("FAIL dw_ctl: got %b want %b", ctl, C_FREEZE); else n_pass++;
    for (int i = 0; i < 254; i++) cyc();
    n_tot++; if (err_o !== 1'b0 || state_o !== 2'd3) $display("FAIL dw_254: got err=%b st=%0d want err=0 st=3", err_o, state_o); else n_pass++;
    cyc();
    n_tot++; if (err_o !== 1'b1) $display("FAIL dw_255: got err=%b want 1", err_o); else n_pass++;
    branch_taken_i = 1'b1; imem_ready_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_FREEZE) $display("FAIL dw_ignore: got %b want %b", ctl, C_FREEZE); else n_pass++;
    for (int i = 0; i < 45; i++) cyc();
    n_tot++; if (err_o !== 1'b1 || ctl !== C_FREEZE) $display("FAIL dw_300: got err=%b ctl=%b want err=1 ctl=%b", err_o, ctl, C_FREEZE); else n_pass++;
    n_tot++; if (stall_cnt_o !== 4'hF || flush_cnt_o !== 4'd0) $display("FAIL dw_cnt: got %0d/%0d want 15/0", stall_cnt_o, flush_cnt_o); else n_pass++;
    dmem_ready_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_BRANCH) $display("FAIL dw_ready_ctl: got %b want %b", ctl, C_BRANCH); else n_pass++;
    cyc();
    branch_taken_i = 1'b0; dmem_req_i = 1'b0;
    #1;
    n_tot++; if (state_o !== 2'd2 || flush_cnt_o !== 4'd1) $display("FAIL dw_restore: got st=%0d fc=%0d want st=2 fc=1", state_o, flush_cnt_o); else n_pass++;
    cyc();
    n_tot++; if (state_o !== 2'd0 || err_o !== 1'b1) $display("FAIL dw_sticky: got st=%0d err=%b want st=0 err=1", state_o, err_o); else n_pass++;
  endtask

  task automatic test_reset_mid_dwait();
    imem_ready_i = 1'b0;
    cyc();
    dmem_req_i = 1'b1; dmem_ready_i = 1'b0;
    cyc(); cyc(); cyc();
    n_tot++; if (state_o !== 2'd3) $display("FAIL mid_pre: got %0d want 3", state_o); else n_pass++;
    rst_i = 1'b0;
    #1;
    n_tot++; if (state_o !== 2'd0 || err_o !== 1'b0) $display("FAIL mid_state: got st=%0d err=%b want 0/0", state_o, err_o); else n_pass++;
    n_tot++; if (stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) $display("FAIL mid_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o); else n_pass++;
    n_tot++; if (ctl !== C_RESET) $display("FAIL mid_ctl: got %b want %b", ctl, C_RESET); else n_pass++;
    cyc();
    idle();
    rst_i = 1'b1;
    #1;
    n_tot++; if (ctl !== C_RUN) $display("FAIL mid_release: got %b want %b", ctl, C_RUN); else n_pass++;
    cyc();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    branch_taken_i = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    branch_taken_i = 1'b0;
    #1;
    n_tot++; if (flush_cnt_o !== 4'hF || stall_cnt_o !== 4'd0) $display("FAIL b2b_sat: got %0d/%0d want 15/0", flush_cnt_o, stall_cnt_o); else n_pass++;
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_fetch_wait();
    test_dmem_timeout();
    test_reset_mid_dwait();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
